// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider with registered o_clk/o_tick and a
// valid/ready divisor reload. Optional duty control under CLK_DIV_PROG_DUTY_EN.
module clk_div_prog #(
  parameter int CTR_W       = 8,
  parameter int DIV_DEFAULT = 6
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [CTR_W-1:0] i_div,
  input  logic             i_div_valid,
`ifdef CLK_DIV_PROG_DUTY_EN
  input  logic [CTR_W-1:0] i_high,
  output logic [CTR_W-1:0] o_active_high,
`endif
  output logic             o_div_ready,
  output logic             o_div_err,
  output logic [CTR_W-1:0] o_active_div,
  output logic             o_clk,
  output logic             o_tick
);

  localparam logic [CTR_W-1:0] DIV_RST  = CTR_W'(DIV_DEFAULT);
  localparam logic [CTR_W-1:0] HIGH_RST = CTR_W'(DIV_DEFAULT / 2);
  localparam logic [CTR_W-1:0] ONE      = CTR_W'(1);
  localparam logic [CTR_W-1:0] TWO      = CTR_W'(2);

  generate
    if (DIV_DEFAULT < 2 || DIV_DEFAULT > (2 ** CTR_W) - 1) begin : g_bad_default
      $error("clk_div_prog: DIV_DEFAULT outside 2 .. 2^CTR_W-1");
    end
  endgenerate

  logic [CTR_W-1:0] cnt_q, cnt_d;
  logic             run_q, run_d;
  logic [CTR_W-1:0] div_q, div_d;
  logic             pend_q, pend_d;
  logic [CTR_W-1:0] pend_div_q, pend_div_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic             err_q, err_d;
  logic [CTR_W-1:0] high_cur;

  logic             accept, reject, wrap, apply;
  logic [CTR_W-1:0] cnt_inc;

`ifdef CLK_DIV_PROG_DUTY_EN
  logic [CTR_W-1:0] high_q, high_d;
  logic [CTR_W-1:0] pend_high_q, pend_high_d;
  logic [CTR_W-1:0] high_clamped;

  // Clamp against the divisor that arrives in the same request.
  always_comb begin
    high_clamped = i_high;
    if (i_high == '0) begin
      high_clamped = ONE;
    end else if (i_high >= i_div) begin
      high_clamped = i_div - ONE;
    end
  end

  assign high_cur      = high_q;
  assign o_active_high = high_q;
`else
  assign high_cur = div_q >> 1;
`endif

  always_comb begin
    accept  = i_div_valid && !pend_q && (i_div >= TWO);
    reject  = i_div_valid && !pend_q && (i_div < TWO);
    wrap    = run_q && (cnt_q == div_q - ONE);
    // A period boundary is a wrap, a (re)start, or any idle edge.
    apply   = pend_q && (!i_en || !run_q || wrap);
    cnt_inc = cnt_q + ONE;

    cnt_d      = cnt_q;
    run_d      = run_q;
    clk_d      = clk_q;
    tick_d     = 1'b0;
    div_d      = div_q;
    pend_d     = pend_q;
    pend_div_d = pend_div_q;
    err_d      = reject;

    if (!i_en) begin
      cnt_d = '0;
      run_d = 1'b0;
      clk_d = 1'b0;
    end else if (!run_q || wrap) begin
      cnt_d  = '0;
      run_d  = 1'b1;
      clk_d  = 1'b1;
      tick_d = 1'b1;
    end else begin
      // Not a boundary, so no apply can be in flight: current H is valid.
      cnt_d = cnt_inc;
      clk_d = (cnt_inc < high_cur);
    end

    if (apply) begin
      div_d  = pend_div_q;
      pend_d = 1'b0;
    end else if (accept) begin
      pend_d     = 1'b1;
      pend_div_d = i_div;
    end
  end

`ifdef CLK_DIV_PROG_DUTY_EN
  always_comb begin
    high_d      = apply ? pend_high_q : high_q;
    pend_high_d = accept ? high_clamped : pend_high_q;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      high_q      <= HIGH_RST;
      pend_high_q <= '0;
    end else begin
      high_q      <= high_d;
      pend_high_q <= pend_high_d;
    end
  end
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q      <= '0;
      run_q      <= 1'b0;
      div_q      <= DIV_RST;
      pend_q     <= 1'b0;
      pend_div_q <= '0;
      clk_q      <= 1'b0;
      tick_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      run_q      <= run_d;
      div_q      <= div_d;
      pend_q     <= pend_d;
      pend_div_q <= pend_div_d;
      clk_q      <= clk_d;
      tick_q     <= tick_d;
      err_q      <= err_d;
    end
  end

  assign o_div_ready  = ~pend_q;
  assign o_div_err    = err_q;
  assign o_active_div = div_q;
  assign o_clk        = clk_q;
  assign o_tick       = tick_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog: waveform, reload handshake, rejection,
// idle/enable behaviour and async reset; duty checks when CLK_DIV_PROG_DUTY_EN is set.
module tb_clk_div_prog;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [7:0] div = 8'd0;
  logic       valid = 1'b0;
  logic       ready, err, oclk, tick;
  logic [7:0] active;
`ifdef CLK_DIV_PROG_DUTY_EN
  logic [7:0] high = 8'd0;
  logic [7:0] active_high;
`endif

  int checks = 0;
  int failures = 0;

  clk_div_prog #(.CTR_W(8), .DIV_DEFAULT(6)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_en         (en),
    .i_div        (div),
    .i_div_valid  (valid),
`ifdef CLK_DIV_PROG_DUTY_EN
    .i_high       (high),
    .o_active_high(active_high),
`endif
    .o_div_ready  (ready),
    .o_div_err    (err),
    .o_active_div (active),
    .o_clk        (oclk),
    .o_tick       (tick)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Steps n cycles; bit n-1 of cv/tv is the expected value of the first cycle.
  task automatic check_seq(input string tag, input int n, input logic [63:0] cv, input logic [63:0] tv);
    for (int i = n - 1; i >= 0; i--) begin
      step();
      chk({tag, "_clk"}, {31'd0, oclk}, {31'd0, cv[i]});
      chk({tag, "_tick"}, {31'd0, tick}, {31'd0, tv[i]});
    end
  endtask

  initial begin
    // Reset values
    step();
    step();
    chk("rst_clk", {31'd0, oclk}, 32'd0);
    chk("rst_tick", {31'd0, tick}, 32'd0);
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_active", {24'd0, active}, 32'd6);
    rst = 1'b0;
    step();
    chk("idle_clk", {31'd0, oclk}, 32'd0);

    // Default N=6: 3 high / 3 low, tick on first high cycle
    en = 1'b1;
    check_seq("n6", 12, 64'b111000111000, 64'b100000100000);

    // N=5 accepted at cycle 2; old period finishes
    check_seq("p3c1", 1, 64'b1, 64'b1);
    div = 8'd5; valid = 1'b1;
    step();
    valid = 1'b0;
    chk("acc5_clk", {31'd0, oclk}, 32'd1);
    chk("acc5_ready", {31'd0, ready}, 32'd0);
    check_seq("old6", 4, 64'b1000, 64'b0000);
    chk("old6_ready", {31'd0, ready}, 32'd0);
    chk("old6_active", {24'd0, active}, 32'd6);
    check_seq("n5a", 1, 64'b1, 64'b1);
    chk("n5_ready", {31'd0, ready}, 32'd1);
    chk("n5_active", {24'd0, active}, 32'd5);
    check_seq("n5b", 9, 64'b100011000, 64'b000010000);

    // Rejections N=1 and N=0
    div = 8'd1; valid = 1'b1;
    step();
    valid = 1'b0;
    chk("rej1_clk", {31'd0, oclk}, 32'd1);
    chk("rej1_tick", {31'd0, tick}, 32'd1);
    chk("rej1_err", {31'd0, err}, 32'd1);
    chk("rej1_ready", {31'd0, ready}, 32'd1);
    step();
    chk("rej1_clr", {31'd0, err}, 32'd0);
    chk("rej1_c2", {31'd0, oclk}, 32'd1);
    div = 8'd0; valid = 1'b1;
    step();
    valid = 1'b0;
    chk("rej0_err", {31'd0, err}, 32'd1);
    chk("rej0_ready", {31'd0, ready}, 32'd1);
    chk("rej0_clk", {31'd0, oclk}, 32'd0);
    step();
    chk("rej0_clr", {31'd0, err}, 32'd0);
    chk("rej0_active", {24'd0, active}, 32'd5);
    check_seq("rej_c5", 1, 64'b0, 64'b0);

    // N=255 accepted on a boundary edge: current period keeps N=5
    div = 8'd255; valid = 1'b1;
    step();
    valid = 1'b0;
    chk("acc255_clk", {31'd0, oclk}, 32'd1);
    chk("acc255_tick", {31'd0, tick}, 32'd1);
    chk("acc255_ready", {31'd0, ready}, 32'd0);
    check_seq("keep5", 4, 64'b1000, 64'b0000);
    chk("keep5_active", {24'd0, active}, 32'd5);
    for (int i = 0; i < 255; i++) begin
      if (i == 100) begin
        div = 8'd2; valid = 1'b1;
      end
      step();
      valid = 1'b0;
      if (i == 0) begin
        chk("n255_active", {24'd0, active}, 32'd255);
        chk("n255_ready", {31'd0, ready}, 32'd1);
      end
      if (i == 100) chk("acc2_ready", {31'd0, ready}, 32'd0);
      chk($sformatf("n255_clk%0d", i), {31'd0, oclk}, {31'd0, (i < 127)});
      chk($sformatf("n255_tick%0d", i), {31'd0, tick}, {31'd0, (i == 0)});
    end
    check_seq("n2", 6, 64'b101010, 64'b101010);
    chk("n2_active", {24'd0, active}, 32'd2);

    // Back to N=6, then drop enable at cycle 4
    div = 8'd6; valid = 1'b1;
    check_seq("acc6", 1, 64'b1, 64'b1);
    valid = 1'b0;
    chk("acc6_ready", {31'd0, ready}, 32'd0);
    check_seq("n2c", 1, 64'b0, 64'b0);
    check_seq("n6b", 3, 64'b111, 64'b100);
    chk("n6b_active", {24'd0, active}, 32'd6);
    en = 1'b0;
    check_seq("off", 1, 64'b0, 64'b0);
    div = 8'd4; valid = 1'b1;
    step();
    valid = 1'b0;
    chk("idle_acc_ready", {31'd0, ready}, 32'd0);
    chk("idle_acc_clk", {31'd0, oclk}, 32'd0);
    step();
    chk("idle_apply_active", {24'd0, active}, 32'd4);
    chk("idle_apply_ready", {31'd0, ready}, 32'd1);
    check_seq("idle", 7, 64'b0, 64'b0);
    en = 1'b1;
    check_seq("n4", 8, 64'b11001100, 64'b10001000);

    // Async reset with N=9 pending
    div = 8'd9; valid = 1'b1;
    step();
    valid = 1'b0;
    chk("acc9_ready", {31'd0, ready}, 32'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_clk", {31'd0, oclk}, 32'd0);
    chk("arst_tick", {31'd0, tick}, 32'd0);
    chk("arst_ready", {31'd0, ready}, 32'd1);
    chk("arst_err", {31'd0, err}, 32'd0);
    chk("arst_active", {24'd0, active}, 32'd6);
    step();
    rst = 1'b0;
    check_seq("post_rst", 6, 64'b111000, 64'b100000);
    chk("post_rst_active", {24'd0, active}, 32'd6);
    chk("post_rst_ready", {31'd0, ready}, 32'd1);

`ifdef CLK_DIV_PROG_DUTY_EN
    chk("duty_rst_high", {24'd0, active_high}, 32'd3);
    en = 1'b0;
    div = 8'd8; high = 8'd0; valid = 1'b1;
    step();
    valid = 1'b0;
    step();
    chk("duty0_active", {24'd0, active}, 32'd8);
    chk("duty0_high", {24'd0, active_high}, 32'd1);
    en = 1'b1;
    check_seq("duty0", 8, 64'b10000000, 64'b10000000);
    en = 1'b0;
    div = 8'd8; high = 8'd12; valid = 1'b1;
    step();
    valid = 1'b0;
    step();
    chk("duty12_high", {24'd0, active_high}, 32'd7);
    chk("duty12_err", {31'd0, err}, 32'd0);
    en = 1'b1;
    check_seq("duty12", 8, 64'b11111110, 64'b10000000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
